// File: rtl/scan_slot_sync_if.sv
// Scan chain bundle: clock, data, select and latch enable travelling slot to slot.
// master drives the chain downstream, slave receives it from upstream.
interface scan_slot_sync_if;
    logic scan_clk;
    logic scan_data;
    logic scan_select;
    logic scan_latch_en;

    modport master (
        output scan_clk,
        output scan_data,
        output scan_select,
        output scan_latch_en
    );

    modport slave (
        input scan_clk,
        input scan_data,
        input scan_select,
        input scan_latch_en
    );
endinterface

// File: rtl/scan_slot_sync.sv
// Scan slot: oversamples the upstream scan chain in clk, shifts/loads, latches design inputs.
// Latency: scan clock rise -> shift update +2 clk, forwarded scan clock +3 clk; latch rise -> design_in +2 clk.
// Backpressure: none; scan levels must be held >= 3 clk, narrower pulses may be lost.
module scan_slot_sync #(
    parameter int NUM_IOS = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    scan_slot_sync_if.slave    up,
    scan_slot_sync_if.master   dn,
    output logic [NUM_IOS-1:0] design_in,
    input  logic [NUM_IOS-1:0] design_out,
    output logic [CNT_W-1:0]   latch_count,
    output logic               frame_err
);

    localparam int            BW   = (NUM_IOS > 1) ? $clog2(NUM_IOS) : 1;
    localparam logic [BW-1:0] LAST = BW'(NUM_IOS - 1);

    logic clk_m, s_clk, s_clk_d;
    logic data_m, s_data;
    logic sel_m, s_sel, s_sel_d;
    logic latch_m, s_latch, s_latch_d;

    logic               clk_out_q;
    logic               sel_out_q;
    logic               latch_out_q;
    logic [NUM_IOS-1:0] shift;
    logic [BW-1:0]      bit_cnt;

    logic clk_rise;
    logic latch_rise;

    assign clk_rise   = s_clk & ~s_clk_d;
    assign latch_rise = s_latch & ~s_latch_d;

    // Forwarded clock comes from s_clk_d, one stage behind the shift update,
    // so the next slot always sees data settled a full clk before its clock edge.
    assign dn.scan_clk      = clk_out_q;
    assign dn.scan_data     = shift[NUM_IOS-1];
    assign dn.scan_select   = sel_out_q;
    assign dn.scan_latch_en = latch_out_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_m       <= 1'b0;
            s_clk       <= 1'b0;
            s_clk_d     <= 1'b0;
            data_m      <= 1'b0;
            s_data      <= 1'b0;
            sel_m       <= 1'b0;
            s_sel       <= 1'b0;
            s_sel_d     <= 1'b0;
            latch_m     <= 1'b0;
            s_latch     <= 1'b0;
            s_latch_d   <= 1'b0;
            clk_out_q   <= 1'b0;
            sel_out_q   <= 1'b0;
            latch_out_q <= 1'b0;
            shift       <= '0;
            bit_cnt     <= '0;
            design_in   <= '0;
            latch_count <= '0;
            frame_err   <= 1'b0;
        end else begin
            clk_m     <= up.scan_clk;
            s_clk     <= clk_m;
            s_clk_d   <= s_clk;
            data_m    <= up.scan_data;
            s_data    <= data_m;
            sel_m     <= up.scan_select;
            s_sel     <= sel_m;
            s_sel_d   <= s_sel;
            latch_m   <= up.scan_latch_en;
            s_latch   <= latch_m;
            s_latch_d <= s_latch;

            clk_out_q   <= s_clk_d;
            sel_out_q   <= s_sel_d;
            latch_out_q <= s_latch_d;

            if (clk_rise) begin
                if (s_sel) begin
                    shift   <= design_out;
                    bit_cnt <= '0;
                end else begin
                    shift   <= {shift[NUM_IOS-2:0], s_data};
                    bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
                end
            end

            // Nonblocking reads give the pre-shift frame when both edges coincide.
            if (latch_rise) begin
                design_in <= shift;
                if (latch_count != '1) begin
                    latch_count <= latch_count + 1'b1;
                end
                if (bit_cnt != '0) begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule
